// File: rtl/mul_long_seq_if.sv
// Handshake bundle between the Execute stage / register-file write port and
// the long-multiply sequencer.
//   master : pipeline side, which drives operands, flush and W-stage port usage
//   slave  : the sequencer, which drives the stall, the write-port request and done
//   E-stage inputs : StartE, SignedE, AccumE, SrcAE, SrcBE, AccLoE, AccHiE,
//                    RdLoE, RdHiE, FlushE
//   Arbitration    : RegWriteW (W stage owns the write port this cycle)
//   Outputs        : StallMul, MulWE, MulWA, MulWD, MulDone
interface mul_long_seq_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 4
);
    logic             StartE;
    logic             SignedE;
    logic             AccumE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] AccLoE;
    logic [WIDTH-1:0] AccHiE;
    logic [REGW-1:0]  RdLoE;
    logic [REGW-1:0]  RdHiE;
    logic             FlushE;
    logic             RegWriteW;
    logic             StallMul;
    logic             MulWE;
    logic [REGW-1:0]  MulWA;
    logic [WIDTH-1:0] MulWD;
    logic             MulDone;

    modport master (
        output StartE, SignedE, AccumE, SrcAE, SrcBE, AccLoE, AccHiE,
               RdLoE, RdHiE, FlushE, RegWriteW,
        input  StallMul, MulWE, MulWA, MulWD, MulDone
    );

    modport slave (
        input  StartE, SignedE, AccumE, SrcAE, SrcBE, AccLoE, AccHiE,
               RdLoE, RdHiE, FlushE, RegWriteW,
        output StallMul, MulWE, MulWA, MulWD, MulDone
    );
endinterface

// File: rtl/mul_long_seq.sv
// Iterative sequencer for UMULL/SMULL/UMLAL/SMLAL beside the Execute stage.
// It computes a 2*WIDTH-bit product by radix-2 shift-add over WIDTH cycles.
// It then applies the sign and the optional accumulate, and writes the Lo and
// Hi halves through the shared register-file port. The W stage always has
// priority on that port.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mul_long_seq_if slave modport (operands, flush, W-port usage in;
//           stall, write request/address/data and done pulse out)
module mul_long_seq #(
    parameter int WIDTH = 32,
    parameter int REGW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    mul_long_seq_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CALC, FIX, WRLO, WRHI} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic               accum;
    logic [REGW-1:0]    rd_lo;
    logic [REGW-1:0]    rd_hi;
    logic [REGW-1:0]    wa;
    logic [WIDTH-1:0]   wd;

    logic               go;
    logic               write_ok;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] fixed;

    always_comb begin
        go       = bus.StartE & ~bus.FlushE;
        write_ok = ~bus.RegWriteW;
        // Unsigned negation keeps the most-negative operand as 2^(WIDTH-1).
        abs_a    = (bus.SignedE & bus.SrcAE[WIDTH-1]) ? -bus.SrcAE : bus.SrcAE;
        abs_b    = (bus.SignedE & bus.SrcBE[WIDTH-1]) ? -bus.SrcBE : bus.SrcBE;
        // Add into the top half, then shift the whole product right. After
        // WIDTH steps the multiplier has been consumed LSB first.
        partial  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        fixed    = neg ? -prod : prod;
        if (accum) begin
            fixed = fixed + acc;
        end
    end

    assign bus.StallMul = reset & ((state == IDLE & go) | (state != IDLE));
    assign bus.MulWE    = (state == WRLO | state == WRHI) & write_ok;
    assign bus.MulDone  = (state == WRHI) & write_ok;
    assign bus.MulWA    = wa;
    assign bus.MulWD    = wd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            accum  <= 1'b0;
            rd_lo  <= '0;
            rd_hi  <= '0;
            wa     <= '0;
            wd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        mcand  <= abs_a;
                        mplier <= abs_b;
                        neg    <= bus.SignedE & (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
                        accum  <= bus.AccumE;
                        acc    <= {bus.AccHiE, bus.AccLoE};
                        rd_lo  <= bus.RdLoE;
                        rd_hi  <= bus.RdHiE;
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    prod   <= {partial, prod[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    // Write address/data are registered one state ahead so
                    // they are already stable when the port request rises.
                    prod  <= fixed;
                    wa    <= rd_lo;
                    wd    <= fixed[WIDTH-1:0];
                    state <= WRLO;
                end
                WRLO: begin
                    if (write_ok) begin
                        wa    <= rd_hi;
                        wd    <= prod[2*WIDTH-1:WIDTH];
                        state <= WRHI;
                    end
                end
                WRHI: begin
                    if (write_ok) begin
                        wa    <= '0;
                        wd    <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_long_seq.sv
// Self-checking bench for mul_long_seq. Expected results come from plain
// 64-bit arithmetic on sign- or zero-extended operands. The expected write
// timing comes from the cycle offset relative to the start cycle.
module tb_mul_long_seq;

    localparam int W  = 32;
    localparam int RW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_long_seq_if #(.WIDTH(W), .REGW(RW)) bus ();

    mul_long_seq #(.WIDTH(W), .REGW(RW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_stall"}, 64'(bus.StallMul), 64'd0);
        chk({tag, "_we"},    64'(bus.MulWE),    64'd0);
        chk({tag, "_wa"},    64'(bus.MulWA),    64'd0);
        chk({tag, "_wd"},    64'(bus.MulWD),    64'd0);
        chk({tag, "_done"},  64'(bus.MulDone),  64'd0);
    endtask

    task automatic drive_idle();
        bus.StartE    = 1'b0;
        bus.FlushE    = 1'b0;
        bus.RegWriteW = 1'b0;
    endtask

    task automatic drive_start(input logic s, input logic ac,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] alo, input logic [31:0] ahi,
                               input logic [3:0] rlo, input logic [3:0] rhi);
        bus.StartE    = 1'b1;
        bus.FlushE    = 1'b0;
        bus.RegWriteW = 1'b0;
        bus.SignedE   = s;
        bus.AccumE    = ac;
        bus.SrcAE     = a;
        bus.SrcBE     = b;
        bus.AccLoE    = alo;
        bus.AccHiE    = ahi;
        bus.RdLoE     = rlo;
        bus.RdHiE     = rhi;
    endtask

    // One complete operation, starting at cycle 0. RegWriteW is forced high
    // on cycles bs..be and, when rb is set, also at random.
    task automatic run_op(input string tag, input logic s, input logic ac,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] alo, input logic [31:0] ahi,
                          input logic [3:0] rlo, input logic [3:0] rhi,
                          input int bs, input int be, input bit rb);
        logic [63:0] ea, eb, expv;
        bit lo_done, hi_done, rw;
        int c;
        ea   = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb   = s ? {{32{b[31]}}, b} : {32'd0, b};
        expv = ea * eb + (ac ? {ahi, alo} : 64'd0);
        lo_done = 1'b0;
        hi_done = 1'b0;

        @(posedge clk); #1;
        drive_start(s, ac, a, b, alo, ahi, rlo, rhi);
        @(negedge clk);
        chk({tag, "_c0_stall"}, 64'(bus.StallMul), 64'd1);
        chk({tag, "_c0_we"},    64'(bus.MulWE),    64'd0);

        c = 0;
        while (!hi_done && c < 200) begin
            c++;
            @(posedge clk); #1;
            // Operand, start and flush activity after acceptance must not
            // disturb the operation in flight.
            bus.StartE  = 1'($urandom);
            bus.FlushE  = 1'($urandom);
            bus.SignedE = 1'($urandom);
            bus.AccumE  = 1'($urandom);
            bus.SrcAE   = $urandom;
            bus.SrcBE   = $urandom;
            bus.AccLoE  = $urandom;
            bus.AccHiE  = $urandom;
            bus.RdLoE   = 4'($urandom);
            bus.RdHiE   = 4'($urandom);
            rw = (c >= bs && c <= be) || (rb && $urandom_range(0, 3) == 0);
            bus.RegWriteW = rw;
            @(negedge clk);
            chk({tag, "_stall"}, 64'(bus.StallMul), 64'd1);
            if (c <= W + 1) begin
                chk({tag, "_calc_we"},   64'(bus.MulWE),   64'd0);
                chk({tag, "_calc_wa"},   64'(bus.MulWA),   64'd0);
                chk({tag, "_calc_wd"},   64'(bus.MulWD),   64'd0);
                chk({tag, "_calc_done"}, 64'(bus.MulDone), 64'd0);
            end else if (rw) begin
                chk({tag, "_defer_we"},   64'(bus.MulWE),   64'd0);
                chk({tag, "_defer_done"}, 64'(bus.MulDone), 64'd0);
            end else if (!lo_done) begin
                chk({tag, "_lo_we"},   64'(bus.MulWE),   64'd1);
                chk({tag, "_lo_wa"},   64'(bus.MulWA),   64'(rlo));
                chk({tag, "_lo_wd"},   64'(bus.MulWD),   64'(expv[31:0]));
                chk({tag, "_lo_done"}, 64'(bus.MulDone), 64'd0);
                lo_done = 1'b1;
            end else begin
                chk({tag, "_hi_we"},   64'(bus.MulWE),   64'd1);
                chk({tag, "_hi_wa"},   64'(bus.MulWA),   64'(rhi));
                chk({tag, "_hi_wd"},   64'(bus.MulWD),   64'(expv[63:32]));
                chk({tag, "_hi_done"}, 64'(bus.MulDone), 64'd1);
                hi_done = 1'b1;
            end
        end
        chk({tag, "_completed"}, 64'(hi_done), 64'd1);

        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check_idle({tag, "_after"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        drive_start(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
        bus.StartE = 1'b0;
        #12;
        check_idle("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        run_op("umull_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd2, 4'd3, 0, -1, 1'b0);
        run_op("umull_contend", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd2, 4'd3, 34, 35, 1'b0);
        run_op("smull_neg", 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'd0, 32'd0, 4'd4, 4'd5, 0, -1, 1'b0);
        run_op("smull_minmin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 4'd6, 4'd7, 0, -1, 1'b0);
        run_op("umlal_carry", 1'b0, 1'b1, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'd0, 4'd8, 4'd9, 0, -1, 1'b0);
        run_op("smlal_min_pos", 1'b1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0, 4'd1, 4'd0, 0, -1, 1'b0);
        run_op("same_rd", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1000, 32'd0, 32'd0, 4'd7, 4'd7, 0, -1, 1'b0);

        // A flushed start is never accepted.
        @(posedge clk); #1;
        drive_start(1'b0, 1'b0, $urandom, $urandom, 32'd0, 32'd0, 4'd1, 4'd2);
        bus.FlushE = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(bus.StallMul), 64'd0);
        chk("flush_we",    64'(bus.MulWE),    64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            chk("flush_idle_stall", 64'(bus.StallMul), 64'd0);
            chk("flush_idle_we",    64'(bus.MulWE),    64'd0);
        end

        // Reset during CALC drops the operation.
        @(posedge clk); #1;
        drive_start(1'b0, 1'b0, 32'h0001_0001, 32'h0000_0010, 32'd0, 32'd0, 4'd3, 4'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive_idle();
        end
        @(negedge clk);
        chk("pre_rst_stall", 64'(bus.StallMul), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("rst_hold");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_idle("rst_dropped");
        end
        run_op("after_rst", 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom), 0, -1, 1'b1);

        for (int n = 0; n < 16; n++) begin
            run_op("rand", 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                   4'($urandom), 4'($urandom), 0, -1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_long_seq.md
Name: mul_long_seq

Overview:
- Iterative sequencer for the long-multiply instructions (UMULL/SMULL/UMLAL/SMLAL), sitting beside the Execute stage.
- Accepts operands from E (SrcAE/SrcBE, plus accumulator RdLo/RdHi values already forwarded by the hazard unit).
- Holds the pipeline stalled while computing a 64-bit result over WIDTH cycles.
- Writes the result into the register file through the shared write port, yielding to the normal W-stage writeback.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- REGW, 4, register-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- StartE  in  1  long-multiply instruction valid in E with condition passed.
- SignedE  in  1  1 = SMULL/SMLAL, 0 = unsigned.
- AccumE  in  1  1 = accumulate variant.
- SrcAE  in  WIDTH  multiplicand (Rm).
- SrcBE  in  WIDTH  multiplier (Rs).
- AccLoE  in  WIDTH  forwarded RdLo value for accumulate.
- AccHiE  in  WIDTH  forwarded RdHi value for accumulate.
- RdLoE  in  REGW  low destination.
- RdHiE  in  REGW  high destination.
- FlushE  in  1  E-stage flush from hazard unit.
- RegWriteW  in  1  pipeline W stage is using the write port this cycle.
- StallMul  out  1  stall request to F/D/E (ORed into hazard stalls).
- MulWE  out  1  write-port request/enable.
- MulWA  out  REGW  write address.
- MulWD  out  WIDTH  write data.
- MulDone  out  1  one-cycle pulse on the final (Hi) write.

Behaviour:
- Reset (reset=0, async): state IDLE; StallMul, MulWE, MulDone = 0; MulWA, MulWD = 0; all internal registers cleared.
- Accept: `go = StartE & ~FlushE`, sampled in IDLE only.
- StallMul is combinational: `StallMul = (state==IDLE & go) | (state!=IDLE)`. The instruction is therefore held in E from the start cycle until its final write.
- States: IDLE -> CALC -> FIX -> WRLO -> WRHI -> IDLE.
- IDLE, on go:
  - Latch |SrcAE| and |SrcBE| (absolute value only when SignedE).
  - Latch the sign flag `neg = SignedE & (SrcAE[msb] ^ SrcBE[msb])`.
  - Latch AccumE, {AccHiE, AccLoE}, RdLoE, RdHiE.
  - Clear the 2*WIDTH product and the counter; go to CALC.
- CALC: radix-2 shift-add, one multiplier bit per cycle, counter 0..WIDTH-1. Exactly WIDTH cycles, then FIX.
- FIX (1 cycle):
  - Negate the product if neg; the magnitude of the most-negative operand is handled as unsigned 2^(WIDTH-1).
  - Then add the accumulator if AccumE.
  - 64-bit modulo arithmetic; carry out is discarded.
- WRLO:
  - If RegWriteW=0: MulWE=1, MulWA=RdLo, MulWD=result[WIDTH-1:0]; go to WRHI.
  - If RegWriteW=1: MulWE=0 and the state holds. The pipeline always has priority and the deferral is unbounded.
- WRHI: same arbitration rule; writes result[2*WIDTH-1:WIDTH] to RdHi, MulDone=1 on the write cycle, then IDLE.
- RdLo==RdHi: both writes are issued; the Hi write lands last and wins (defined behaviour).
- Outside WRLO/WRHI: MulWE=0 and MulWA/MulWD=0.
- Timing with the start at cycle 0:
  - CALC in cycles 1..WIDTH; FIX at WIDTH+1.
  - Lo write at WIDTH+2 and Hi write at WIDTH+3 when there is no contention.
  - StallMul is high in cycles 0..WIDTH+3 inclusive, low the cycle after the Hi write.
- FlushE=1 with StartE=1 in IDLE: no accept, StallMul stays 0.
- FlushE or StartE outside IDLE: ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No partial write completes; a pending write is dropped.

Test Plan:
- Unsigned 0xFFFFFFFF*0xFFFFFFFF, RdLo=2, RdHi=3, start cycle 0:
  - Cycle 34: MulWE=1, MulWA=2, MulWD=0x00000001.
  - Cycle 35: MulWA=3, MulWD=0xFFFFFFFE, MulDone=1.
  - StallMul high cycles 0..35.
- Signed 0xFFFFFFFE*0x00000003 (-2*3) -> Lo 0xFFFFFFFA, Hi 0xFFFFFFFF.
- Signed 0x80000000*0x80000000 -> Lo 0x00000000, Hi 0x40000000.
- UMLAL 2*3, AccLo=0xFFFFFFFF, AccHi=0 -> Lo 0x00000005, Hi 0x00000001 (carry into Hi).
- RegWriteW=1 at cycles 34-35:
  - MulWE=0 in both cycles; Lo write at cycle 36, Hi at 37.
  - StallMul extends through cycle 37.
- StartE=1 with FlushE=1 -> StallMul=0, no MulWE ever.
- Reset pulsed low at cycle 10 of CALC -> outputs 0 immediately, no writes; a fresh start afterwards produces a correct result.
